ram_march_tester: RTL and testbench

RAM_MARCH_TESTER -- requirements
Module: ram_march_tester

---
 rtl/ram_test_pkg.sv | 43 ++++
 rtl/ram_8x8.sv | 25 ++
 rtl/ram_march_tester_addr_cnt.sv | 35 +++
 rtl/ram_march_tester.sv | 138 +++++++++++++
 tb/tb_ram_march_tester.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_test_pkg.sv
// Shared definitions for the March C- RAM tester: FSM states, march element table
// and the two data backgrounds.
package ram_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CMP,
        S_DONE
    } state_t;

    // One march element: sweep direction, expected read background, written
    // background, and which of the read / write operations it performs.
    typedef struct packed {
        logic down;
        logic rd_exp;
        logic wr_pat;
        logic has_rd;
        logic has_wr;
    } elem_t;

    localparam logic       P0        = 1'b0;
    localparam logic       P1        = 1'b1;
    localparam logic [2:0] LAST_ELEM = 3'd5;
    localparam logic [7:0] ERR_MAX   = 8'hFF;

    function automatic elem_t march_elem(input logic [2:0] idx);
        elem_t e;
        e = '0;
        case (idx)
            3'd0:    e = '{down: 1'b0, rd_exp: P0, wr_pat: P0, has_rd: 1'b0, has_wr: 1'b1};
            3'd1:    e = '{down: 1'b0, rd_exp: P0, wr_pat: P1, has_rd: 1'b1, has_wr: 1'b1};
            3'd2:    e = '{down: 1'b0, rd_exp: P1, wr_pat: P0, has_rd: 1'b1, has_wr: 1'b1};
            3'd3:    e = '{down: 1'b1, rd_exp: P0, wr_pat: P1, has_rd: 1'b1, has_wr: 1'b1};
            3'd4:    e = '{down: 1'b1, rd_exp: P1, wr_pat: P0, has_rd: 1'b1, has_wr: 1'b1};
            3'd5:    e = '{down: 1'b1, rd_exp: P0, wr_pat: P0, has_rd: 1'b1, has_wr: 1'b0};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ram_8x8.sv
// Single-port synchronous RAM with one-cycle registered read, used as the
// device under test for the march tester.
module ram_8x8 #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the storage array has no reset; clearing a memory needs a write per
    // word and would stop it mapping onto RAM macros.
    always_ff @(posedge clk) begin
        if (rw) begin
            mem[addr] <= data_in;
        end
        data_out <= mem[addr];
    end

endmodule

// File: rtl/ram_march_tester_addr_cnt.sv
// March address sweep counter: loads the first address of an element, steps in
// the element's direction and flags the element's last address.
module march_addr_cnt
    import ram_test_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic              down,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic down_q;

    // NOTE: clocked state uses <= so every register samples pre-edge values;
    // blocking = here would let later statements see already-updated values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            addr   <= '0;
            down_q <= 1'b0;
        end else if (load) begin
            down_q <= down;
            addr   <= down ? '1 : '0;
        end else if (step) begin
            addr <= down_q ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
        end
    end

    assign last = down_q ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/ram_march_tester.sv
// March C- RAM tester: drives a synchronous RAM through the six march elements
// and reports pass/fail, first failing address/data and a saturating error count.
module ram_march_tester
    import ram_test_pkg::*;
#(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    output logic              rw,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [7:0]        err_count
);

    state_t            state, state_nx;
    logic [2:0]        elem, elem_nx;
    elem_t             cur, adv, nxt;
    logic              cnt_load, cnt_step, cnt_down, cnt_last;
    logic [ADDR_W-1:0] cnt_addr;
    logic              start_ok, mismatch;

    assign cur = march_elem(elem);
    assign adv = march_elem(elem + 3'd1);
    assign nxt = march_elem(elem_nx);

    assign mismatch = (state == S_CMP) && (data_out != {DATA_W{cur.rd_exp}});

    march_addr_cnt #(.ADDR_W(ADDR_W)) u_cnt (
        .clk  (clk),
        .clr  (clr),
        .load (cnt_load),
        .down (cnt_down),
        .step (cnt_step),
        .addr (cnt_addr),
        .last (cnt_last)
    );

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would infer a latch.
    always_comb begin
        state_nx = state;
        elem_nx  = elem;
        cnt_load = 1'b0;
        cnt_step = 1'b0;
        cnt_down = adv.down;
        start_ok = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_nx = S_WR;
                    elem_nx  = '0;
                    cnt_load = 1'b1;
                    cnt_down = march_elem(3'd0).down;
                end
            end
            S_WR: begin
                if (cnt_last) begin
                    // Next element starts straight away at its first address.
                    elem_nx  = elem + 3'd1;
                    cnt_load = 1'b1;
                    state_nx = adv.has_rd ? S_RD : S_WR;
                end else begin
                    cnt_step = 1'b1;
                    state_nx = cur.has_rd ? S_RD : S_WR;
                end
            end
            S_RD: state_nx = S_CMP;
            S_CMP: begin
                if (mismatch && STOP_ON_FAIL) begin
                    state_nx = S_DONE;
                end else if (cur.has_wr) begin
                    state_nx = S_WR;
                end else if (cnt_last || elem != LAST_ELEM) begin
                    state_nx = S_DONE;
                end else begin
                    cnt_step = 1'b1;
                    state_nx = S_RD;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= S_IDLE;
            elem    <= '0;
            data_in <= '0;
        end else begin
            state <= state_nx;
            elem  <= elem_nx;
            if (state_nx == S_WR) begin
                data_in <= {DATA_W{nxt.wr_pat}};
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (start_ok) begin
            pass      <= 1'b1;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (mismatch) begin
            if (err_count != ERR_MAX) begin
                err_count <= err_count + 8'd1;
            end
            // pass still high means this is the first mismatch of the run.
            if (pass) begin
                fail_addr <= cnt_addr;
                fail_data <= data_out;
            end
            pass <= 1'b0;
        end
    end

    assign rw   = (state == S_WR);
    assign busy = (state == S_WR) || (state == S_RD) || (state == S_CMP);
    assign done = (state == S_DONE);
    assign addr = busy ? cnt_addr : '0;

endmodule

// File: tb/tb_ram_march_tester.sv
// Scoreboard bench: two testers (STOP_ON_FAIL 0 and 1) each on its own RAM,
// with injectable read faults; end-of-test results checked by a monitor.
module tb_ram_march_tester;

    typedef struct {
        int         cycles;
        logic       pass;
        logic [7:0] errs;
        logic [3:0] faddr;
        logic [7:0] fdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr;
    logic [1:0] start;
    logic [1:0] fault_mode;

    logic [1:0] rw, busy, done, pass;
    logic [3:0] addr      [2];
    logic [7:0] data_in   [2];
    logic [7:0] rd_data   [2];
    logic [3:0] fail_addr [2];
    logic [7:0] fail_data [2];
    logic [7:0] err_count [2];

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [3:0] rd_addr_q;
        logic [7:0] ram_q;

        ram_march_tester #(.ADDR_W(4), .DATA_W(8), .STOP_ON_FAIL(g == 1)) u_dut (
            .clk       (clk),
            .clr       (clr),
            .start     (start[g]),
            .rw        (rw[g]),
            .addr      (addr[g]),
            .data_in   (data_in[g]),
            .data_out  (rd_data[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .pass      (pass[g]),
            .fail_addr (fail_addr[g]),
            .fail_data (fail_data[g]),
            .err_count (err_count[g])
        );

        ram_8x8 #(.ADDR_W(4), .DATA_W(8)) u_ram (
            .clk      (clk),
            .rw       (rw[g]),
            .addr     (addr[g]),
            .data_in  (data_in[g]),
            .data_out (ram_q)
        );

        always_ff @(posedge clk) rd_addr_q <= addr[g];

        // Fault 1: location 5 bit 0 stuck-at-1; fault 2: every read returns 8'hFF.
        assign rd_data[g] = (fault_mode == 2'd2) ? 8'hFF :
                            (fault_mode == 2'd1 && rd_addr_q == 4'd5) ? (ram_q | 8'h01) : ram_q;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns one step after the sampling edge, i.e. in busy cycle 1.
    task automatic pulse_start(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int   n = 0;
        logic timed_out;
        while (!done[i] && n < budget) begin
            step(1);
            n++;
        end
        timed_out = !done[i];
        check($sformatf("done_timeout%0d", i), timed_out, 0);
        @(negedge clk);
        #1;
        check($sformatf("done_rw%0d", i), rw[i], 0);
        check($sformatf("done_addr%0d", i), addr[i], 0);
        check($sformatf("done_busy%0d", i), busy[i], 0);
    endtask

    task automatic check_all_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_rw"}, rw[i], 0);
            check({tag, "_addr"}, addr[i], 0);
            check({tag, "_data_in"}, data_in[i], 0);
            check({tag, "_busy"}, busy[i], 0);
            check({tag, "_done"}, done[i], 0);
            check({tag, "_pass"}, pass[i], 0);
            check({tag, "_fail_addr"}, fail_addr[i], 0);
            check({tag, "_fail_data"}, fail_data[i], 0);
            check({tag, "_err_count"}, err_count[i], 0);
        end
    endtask

    // Monitor: measures busy length and checks results on each rising done.
    initial begin
        int   bcnt [2];
        logic done_prev [2];
        exp_t e;
        bcnt      = '{0, 0};
        done_prev = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!clr) bcnt[i] = 0;
                else if (busy[i]) bcnt[i]++;
                if (done[i] === 1'b1 && !done_prev[i]) begin
                    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_done dut=%0d actual=done expected=none", i);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("sb%0d_busy_cycles", i), bcnt[i], e.cycles);
                        check($sformatf("sb%0d_pass", i), pass[i], e.pass);
                        check($sformatf("sb%0d_err_count", i), err_count[i], e.errs);
                        check($sformatf("sb%0d_fail_addr", i), fail_addr[i], e.faddr);
                        check($sformatf("sb%0d_fail_data", i), fail_data[i], e.fdata);
                    end
                    bcnt[i] = 0;
                end
                done_prev[i] = done[i];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        clr        = 1'b0;
        start      = 2'b00;
        fault_mode = 2'd0;
        #3;
        check_all_reset("reset");
        @(negedge clk);
        clr = 1'b1;

        // Clean RAM, with spot checks of the address/control sequence.
        q0.push_back('{240, 1'b1, 8'd0, 4'd0, 8'h00});
        pulse_start(0);
        check("c1_busy", busy[0], 1);
        check("c1_done", done[0], 0);
        check("c1_pass", pass[0], 1);
        check("c1_err", err_count[0], 0);
        check("c1_rw", rw[0], 1);
        check("c1_addr", addr[0], 0);
        check("c1_data_in", data_in[0], 8'h00);
        step(15);
        check("c16_rw", rw[0], 1);
        check("c16_addr", addr[0], 15);
        step(1);
        check("c17_rw", rw[0], 0);
        check("c17_addr", addr[0], 0);
        step(1);
        check("c18_rw", rw[0], 0);
        check("c18_data_in_hold", data_in[0], 8'h00);
        step(1);
        check("c19_rw", rw[0], 1);
        check("c19_addr", addr[0], 0);
        check("c19_data_in", data_in[0], 8'hFF);
        step(94);
        check("c113_rw", rw[0], 0);
        check("c113_addr", addr[0], 15);
        check("c113_data_in_hold", data_in[0], 8'h00);
        wait_done(0, 400);
        step(3);
        check("done_held", done[0], 1);

        // Start re-pulsed while busy must be ignored.
        q0.push_back('{240, 1'b1, 8'd0, 4'd0, 8'h00});
        pulse_start(0);
        step(8);
        pulse_start(0);
        check("repulse_busy", busy[0], 1);
        step(188);
        pulse_start(0);
        check("repulse_err", err_count[0], 0);
        wait_done(0, 400);

        // Location 5 bit 0 stuck-at-1, run to completion.
        fault_mode = 2'd1;
        q0.push_back('{240, 1'b0, 8'd3, 4'd5, 8'h01});
        pulse_start(0);
        check("stuck_start_pass", pass[0], 1);
        wait_done(0, 400);

        // Same fault, stop on first failure: ends after the M1 addr-5 compare.
        q1.push_back('{33, 1'b0, 8'd1, 4'd5, 8'h01});
        pulse_start(1);
        wait_done(1, 400);

        // Every read returns all ones.
        fault_mode = 2'd2;
        q0.push_back('{240, 1'b0, 8'd48, 4'd0, 8'hFF});
        pulse_start(0);
        wait_done(0, 400);

        // Reset mid-test, then a fresh full run.
        fault_mode = 2'd0;
        pulse_start(0);
        step(99);
        check("pre_clr_busy", busy[0], 1);
        clr = 1'b0;
        #1;
        check_all_reset("midclr");
        @(negedge clk);
        clr = 1'b1;
        step(5);
        check("no_resume_busy", busy[0], 0);
        check("no_resume_done", done[0], 0);
        check("no_resume_rw", rw[0], 0);
        q0.push_back('{240, 1'b1, 8'd0, 4'd0, 8'h00});
        pulse_start(0);
        wait_done(0, 400);

        step(2);
        check("sb0_drained", q0.size(), 0);
        check("sb1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
